// File: rtl/lb_slave_regfile_if.sv
// Local-bus request/response bundle between the LB master and a register-file slave.
// The master drives write/read requests; the slave returns read data with a finish pulse.
interface lb_slave_regfile_if;
  logic        wreq;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        rreq;
  logic [15:0] raddr;
  logic [31:0] rdata;
  logic        rfinish;

  modport master (
    output wreq, waddr, wdata, rreq, raddr,
    input  rdata, rfinish
  );

  modport slave (
    input  wreq, waddr, wdata, rreq, raddr,
    output rdata, rfinish
  );
endinterface

// File: rtl/lb_slave_regfile.sv
// Local-bus slave register file: R/W control words, RO status words, snapshot reads
// returned after a fixed latency with a one-cycle finish pulse.
//
// state  | meaning
// IDLE   | no read in flight; a read edge is accepted and snapshotted
// WAIT   | latency countdown; read edges are dropped (overrun)
// DONE   | snapshot is transferred to rdata on the next edge; read edges dropped
module lb_slave_regfile #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          NUM_REGS   = 8,
  parameter int          NUM_STAT   = 4,
  parameter int          RD_LAT     = 2,
  parameter logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF,
  parameter logic [31:0] RST_VAL    = 32'h0
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  lb_slave_regfile_if.slave                            s_lb,
  output logic [32*NUM_REGS-1:0]                       o_reg_out,
  output logic [NUM_REGS-1:0]                          o_wr_stb,
  input  logic [32*((NUM_STAT > 0) ? NUM_STAT : 1)-1:0] i_stat_in,
  output logic                                         o_wr_err,
  output logic                                         o_rd_ovr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} t_state;

  t_state              r_state, w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_wreq_d, r_rreq_d;
  logic [31:0]         r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_stb_pend;
  logic                r_err_pend, r_ovr_pend;
  logic [31:0]         r_rd_hold, r_rdata;
  logic                r_rfinish;

  logic        w_wr_acc, w_rd_edge, w_load, w_drop, w_done;
  logic [16:0] w_wr_off, w_rd_off;
  logic [13:0] w_wr_idx, w_rd_idx;
  logic        w_wr_rw, w_rd_rw, w_rd_ro;
  logic [31:0] w_rd_snap;

  // 17-bit difference: bit 16 set means the address lies below BASE_ADDR (no wrap).
  assign w_wr_off = {1'b0, s_lb.waddr} - {1'b0, BASE_ADDR};
  assign w_rd_off = {1'b0, s_lb.raddr} - {1'b0, BASE_ADDR};
  assign w_wr_idx = w_wr_off[15:2];
  assign w_rd_idx = w_rd_off[15:2];
  assign w_wr_rw  = (w_wr_off[1:0] == 2'b00) && !w_wr_off[16] && (w_wr_idx < 14'(NUM_REGS));
  assign w_rd_rw  = (w_rd_off[1:0] == 2'b00) && !w_rd_off[16] && (w_rd_idx < 14'(NUM_REGS));
  assign w_rd_ro  = (w_rd_off[1:0] == 2'b00) && !w_rd_off[16] && (w_rd_idx >= 14'(NUM_REGS))
                    && (w_rd_idx < 14'(NUM_REGS + NUM_STAT));

  assign w_wr_acc  = s_lb.wreq && !r_wreq_d;
  assign w_rd_edge = s_lb.rreq && !r_rreq_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wreq_d <= 1'b0;
      r_rreq_d <= 1'b0;
    end else begin
      r_wreq_d <= s_lb.wreq;
      r_rreq_d <= s_lb.rreq;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_VAL;
      r_stb_pend <= '0;
      r_err_pend <= 1'b0;
      o_wr_stb   <= '0;
      o_wr_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_stb_pend[i] <= w_wr_acc && w_wr_rw && (w_wr_idx == 14'(i));
        if (w_wr_acc && w_wr_rw && (w_wr_idx == 14'(i))) r_regs[i] <= s_lb.wdata;
      end
      r_err_pend <= w_wr_acc && !w_wr_rw;
      o_wr_stb   <= r_stb_pend;
      o_wr_err   <= r_err_pend;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign o_reg_out[32*g +: 32] = r_regs[g];
  end

  // r_regs is read here before the same-edge write lands, giving read-before-write.
  always_comb begin
    w_rd_snap = RD_DEFAULT;
    if (w_rd_rw) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_rd_idx == 14'(i)) w_rd_snap = r_regs[i];
    end else if (w_rd_ro) begin
      for (int j = 0; j < NUM_STAT; j++)
        if (w_rd_idx == 14'(NUM_REGS + j)) w_rd_snap = i_stat_in[32*j +: 32];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)                r_cnt <= 4'(RD_LAT - 1);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  // The counter reaches zero on the same edge that enters DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rd_edge) w_state_nxt = (RD_LAT == 1) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state == S_IDLE) && w_rd_edge;
    w_drop = (r_state != S_IDLE) && w_rd_edge;
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_hold  <= '0;
      r_rdata    <= '0;
      r_rfinish  <= 1'b0;
      r_ovr_pend <= 1'b0;
      o_rd_ovr   <= 1'b0;
    end else begin
      if (w_load) r_rd_hold <= w_rd_snap;
      if (w_done) r_rdata <= r_rd_hold;
      r_rfinish  <= w_done;
      r_ovr_pend <= w_drop;
      o_rd_ovr   <= r_ovr_pend;
    end
  end

  assign s_lb.rdata   = r_rdata;
  assign s_lb.rfinish = r_rfinish;

endmodule

// File: tb/tb_lb_slave_regfile.sv
// Directed bench for lb_slave_regfile with default parameters (8 R/W regs, 4 status words, 2-cycle reads).
// Inputs change and outputs are sampled on the falling edge.
module tb_lb_slave_regfile;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] reg_out;
  logic [7:0]   wr_stb;
  logic [127:0] stat_in;
  logic         wr_err, rd_ovr;
  logic [31:0]  m_regs [8];
  int           n_tests = 0;
  int           n_fail  = 0;

  lb_slave_regfile_if u_if ();

  lb_slave_regfile u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .s_lb      (u_if),
    .o_reg_out (reg_out),
    .o_wr_stb  (wr_stb),
    .i_stat_in (stat_in),
    .o_wr_err  (wr_err),
    .o_rd_ovr  (rd_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_regs();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m_regs[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
    u_if.rreq = 1'b1; u_if.raddr = a;
    tick();
    u_if.rreq = 1'b0;
    chk_eq({tag, "_fin_t0"}, u_if.rfinish, 0);
    tick();
    chk_eq({tag, "_fin_t1"}, u_if.rfinish, 0);
    tick();
    chk_eq({tag, "_fin_t2"}, u_if.rfinish, 1);
    chk_eq({tag, "_data"}, u_if.rdata, exp);
    chk_eq({tag, "_ovr"}, rd_ovr, 0);
    tick();
    chk_eq({tag, "_fin_t3"}, u_if.rfinish, 0);
    chk_eq({tag, "_hold"}, u_if.rdata, exp);
  endtask

  task automatic write_chk(input logic [15:0] a, input logic [31:0] d, input bit rw,
                           input int idx, input string tag);
    logic [7:0] exp_stb;
    u_if.wreq = 1'b1; u_if.waddr = a; u_if.wdata = d;
    tick();
    u_if.wreq = 1'b0;
    if (rw) m_regs[idx] = d;
    exp_stb = rw ? (8'd1 << idx) : 8'd0;
    chk_eq({tag, "_reg"}, reg_out, pack_regs());
    chk_eq({tag, "_stb_t0"}, wr_stb, 0);
    tick();
    chk_eq({tag, "_stb_t1"}, wr_stb, exp_stb);
    chk_eq({tag, "_err_t1"}, wr_err, !rw);
    tick();
    chk_eq({tag, "_stb_t2"}, wr_stb, 0);
    chk_eq({tag, "_err_t2"}, wr_err, 0);
  endtask

  initial begin
    int n_fin, n_ovr;
    rst = 1'b1;
    u_if.wreq = 1'b0; u_if.waddr = '0; u_if.wdata = '0;
    u_if.rreq = 1'b0; u_if.raddr = '0;
    stat_in = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_F00D};
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    repeat (2) @(negedge clk);

    chk_eq("rst_regs", reg_out, pack_regs());
    chk_eq("rst_rdata", u_if.rdata, 0);
    chk_eq("rst_fin", u_if.rfinish, 0);
    chk_eq("rst_stb", wr_stb, 0);
    chk_eq("rst_err", wr_err, 0);
    chk_eq("rst_ovr", rd_ovr, 0);
    rst = 1'b0;
    tick();

    do_read(16'h0000, 32'h0, "rd_reg0");
    write_chk(16'h0004, 32'hA5A5_0001, 1'b1, 1, "wr_reg1");
    write_chk(16'h001C, 32'h7777_0007, 1'b1, 7, "wr_reg7");

    // Same-edge write and read of one address: old value comes back.
    u_if.wreq = 1'b1; u_if.waddr = 16'h0008; u_if.wdata = 32'h1234_5678;
    u_if.rreq = 1'b1; u_if.raddr = 16'h0008;
    tick();
    u_if.wreq = 1'b0; u_if.rreq = 1'b0;
    m_regs[2] = 32'h1234_5678;
    chk_eq("rw8_reg", reg_out, pack_regs());
    tick(); tick();
    chk_eq("rw8_fin", u_if.rfinish, 1);
    chk_eq("rw8_old", u_if.rdata, 32'h0);
    tick();
    do_read(16'h0008, 32'h1234_5678, "rd_reg2");

    u_if.wreq = 1'b1; u_if.waddr = 16'h0004; u_if.wdata = 32'h0BAD_0004;
    u_if.rreq = 1'b1; u_if.raddr = 16'h0004;
    tick();
    u_if.wreq = 1'b0; u_if.rreq = 1'b0;
    m_regs[1] = 32'h0BAD_0004;
    tick(); tick();
    chk_eq("rw4_fin", u_if.rfinish, 1);
    chk_eq("rw4_old", u_if.rdata, 32'hA5A5_0001);
    tick();

    // Write during WAIT must not disturb the in-flight snapshot.
    u_if.rreq = 1'b1; u_if.raddr = 16'h0004;
    tick();
    u_if.rreq = 1'b0;
    u_if.wreq = 1'b1; u_if.waddr = 16'h0004; u_if.wdata = 32'h5555_AAAA;
    tick();
    u_if.wreq = 1'b0;
    m_regs[1] = 32'h5555_AAAA;
    tick();
    chk_eq("snap_fin", u_if.rfinish, 1);
    chk_eq("snap_data", u_if.rdata, 32'h0BAD_0004);
    chk_eq("snap_reg", reg_out, pack_regs());
    tick(); tick();

    do_read(16'h0020, 32'hCAFE_F00D, "rd_stat0");
    do_read(16'h002C, 32'h3333_0003, "rd_stat3");
    do_read(16'h0030, 32'hDEAD_BEEF, "rd_unmap30");
    do_read(16'h0040, 32'hDEAD_BEEF, "rd_unmap40");
    do_read(16'h0006, 32'hDEAD_BEEF, "rd_unalign");
    write_chk(16'h0020, 32'hFFFF_FFFF, 1'b0, 0, "wr_ro");
    write_chk(16'h0002, 32'hFFFF_FFFF, 1'b0, 0, "wr_unalign");
    write_chk(16'h0040, 32'hFFFF_FFFF, 1'b0, 0, "wr_unmap");

    // Second read edge lands in DONE: dropped with one overrun pulse.
    u_if.rreq = 1'b1; u_if.raddr = 16'h0020;
    tick();
    u_if.rreq = 1'b0;
    tick();
    u_if.rreq = 1'b1; u_if.raddr = 16'h0008;
    tick();
    u_if.rreq = 1'b0;
    chk_eq("ovr_fin", u_if.rfinish, 1);
    chk_eq("ovr_data", u_if.rdata, 32'hCAFE_F00D);
    chk_eq("ovr_t2", rd_ovr, 0);
    tick();
    chk_eq("ovr_t3", rd_ovr, 1);
    chk_eq("ovr_fin_t3", u_if.rfinish, 0);
    tick();
    chk_eq("ovr_t4", rd_ovr, 0);
    n_fin = 0;
    repeat (3) begin tick(); n_fin += int'(u_if.rfinish); end
    chk_eq("ovr_no_2nd", n_fin, 0);

    // Read edge in the cycle RFINISH is high (FSM back in IDLE) is accepted.
    u_if.rreq = 1'b1; u_if.raddr = 16'h0000;
    tick();
    u_if.rreq = 1'b0;
    tick(); tick();
    chk_eq("b2b_fin1", u_if.rfinish, 1);
    u_if.rreq = 1'b1; u_if.raddr = 16'h0008;
    tick();
    u_if.rreq = 1'b0;
    tick();
    chk_eq("b2b_ovr", rd_ovr, 0);
    tick();
    chk_eq("b2b_fin2", u_if.rfinish, 1);
    chk_eq("b2b_data2", u_if.rdata, 32'h1234_5678);
    tick();

    n_fin = 0; n_ovr = 0;
    u_if.rreq = 1'b1; u_if.raddr = 16'h0024;
    repeat (10) begin tick(); n_fin += int'(u_if.rfinish); n_ovr += int'(rd_ovr); end
    u_if.rreq = 1'b0;
    repeat (3) begin tick(); n_fin += int'(u_if.rfinish); n_ovr += int'(rd_ovr); end
    chk_eq("held_fin", n_fin, 1);
    chk_eq("held_ovr", n_ovr, 0);
    chk_eq("held_data", u_if.rdata, 32'h1111_0001);

    // Reset during WAIT: no finish, registers back to reset value.
    u_if.rreq = 1'b1; u_if.raddr = 16'h0004;
    tick();
    u_if.rreq = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    chk_eq("mid_rst_regs", reg_out, pack_regs());
    chk_eq("mid_rst_rdata", u_if.rdata, 0);
    n_fin = 0;
    repeat (2) begin tick(); n_fin += int'(u_if.rfinish); end
    u_if.rreq = 1'b1; u_if.raddr = 16'h0020;
    tick();
    n_fin += int'(u_if.rfinish);
    chk_eq("mid_rst_nofin", n_fin, 0);
    rst = 1'b0;
    tick();
    chk_eq("rel_fin_t0", u_if.rfinish, 0);
    tick();
    chk_eq("rel_fin_t1", u_if.rfinish, 0);
    tick();
    chk_eq("rel_fin_t2", u_if.rfinish, 1);
    chk_eq("rel_data", u_if.rdata, 32'hCAFE_F00D);
    u_if.rreq = 1'b0;
    tick();
    chk_eq("rel_fin_t3", u_if.rfinish, 0);
    do_read(16'h0004, 32'h0, "rd_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
